branch_target_predictor: RTL

//   Direct-mapped branch target buffer with 2-bit saturating direction counters.

---
 rtl/branch_target_predictor.sv | 102 ++++++++++
 1 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Predicts combinationally from registered state; trains from execute-stage resolution.
module branch_target_predictor #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     lookup_pc_i,
  output logic                 pred_taken_o,
  output logic [WIDTH-1:0]     pred_target_o,
  input  logic                 update_valid_i,
  input  logic [WIDTH-1:0]     update_pc_i,
  input  logic                 update_taken_i,
  input  logic [WIDTH-1:0]     update_target_i,
  input  logic                 update_pred_taken_i,
  input  logic [WIDTH-1:0]     update_pred_tgt_i,
  output logic                 mispredict_o,
  output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

  localparam int unsigned Entries  = 1 << INDEX_BITS;
  localparam int unsigned TagWidth = WIDTH - INDEX_BITS - 2;

  logic                 valid_q  [Entries];
  logic [TagWidth-1:0]  tag_q    [Entries];
  logic [WIDTH-1:0]     target_q [Entries];
  logic [1:0]           ctr_q    [Entries];
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [INDEX_BITS-1:0] lkp_idx, upd_idx;
  logic [TagWidth-1:0]   lkp_tag, upd_tag;
  logic                  lkp_hit, upd_hit;
  logic [1:0]            upd_ctr, ctr_inc, ctr_dec;

  // Word-aligned PCs: bits [1:0] never index or tag an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^update_pc_i[1:0];

  assign lkp_idx = lookup_pc_i[INDEX_BITS+1:2];
  assign lkp_tag = lookup_pc_i[WIDTH-1:INDEX_BITS+2];
  assign upd_idx = update_pc_i[INDEX_BITS+1:2];
  assign upd_tag = update_pc_i[WIDTH-1:INDEX_BITS+2];

  assign lkp_hit = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    pred_taken_o  = lkp_hit && ctr_q[lkp_idx][1];
    pred_target_o = pred_taken_o ? target_q[lkp_idx] : lookup_pc_i + WIDTH'(4);
  end

  always_comb begin
    upd_ctr = ctr_q[upd_idx];
    ctr_inc = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
    ctr_dec = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
  end

  always_comb begin
    mispredict_o = update_valid_i &&
                   ((update_pred_taken_i != update_taken_i) ||
                    (update_taken_i && (update_pred_tgt_i != update_target_i)));
    cnt_d = cnt_q;
    if (mispredict_o && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  assign mispredict_cnt_o = cnt_q;

  // Valid bits and counters carry reset; tags/targets are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (update_valid_i) begin
        if (upd_hit) begin
          ctr_q[upd_idx] <= update_taken_i ? ctr_inc : ctr_dec;
        end else if (update_taken_i) begin
          valid_q[upd_idx] <= 1'b1;
          ctr_q[upd_idx]   <= 2'b10;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && update_valid_i && update_taken_i) begin
      target_q[upd_idx] <= update_target_i;
      if (!upd_hit) begin
        tag_q[upd_idx] <= upd_tag;
      end
    end
  end

endmodule
